// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the PhilosophyV instruction-fetch stage:
// FSM state encodings, the instruction words fetch cares about, and the PC step.
package fetch_unit_pkg;

  // Fetch sequencer states (2-bit encoding).
  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  // addi x0,x0,0: harmless filler shown on out_instr before the first fetch.
  localparam logic [31:0] NOP_WORD   = 32'h0000_0013;
  // ECALL stops the fetch stream until a redirect arrives.
  localparam logic [31:0] ECALL_WORD = 32'h0000_0073;
  // Instructions are 32-bit, so the PC advances one word per fetch.
  localparam int unsigned PC_STEP    = 4;

endpackage : fetch_unit_pkg

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's bus signals: instruction-memory port, redirect
// input, IF/ID valid/ready handshake towards decode, and status outputs.
interface fetch_unit_if #(
  parameter int N = 32
);

  logic [N-1:0] imem_addr;
  logic [N-1:0] imem_data;
  logic         redirect_valid;
  logic [N-1:0] redirect_pc;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_pc;
  logic [N-1:0] out_instr;
  logic         halted;
  logic [N-1:0] fetch_count;

  // View of the fetch unit itself.
  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_instr,
    output halted,
    output fetch_count
  );

  // View of the surrounding pipeline: memory, branch unit and decode.
  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_instr,
    input  halted,
    input  fetch_count
  );

endinterface : fetch_unit_if

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register: reset to RESET_PC, load on redirect (highest
// priority), increment by one instruction word, otherwise hold.
module pc_reg
  import fetch_unit_pkg::*;
#(
  parameter int          N        = 32,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] load_pc,
  input  logic         inc,
  output logic [N-1:0] pc
);

  // PC update: load beats increment; addition wraps modulo 2^N.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values of its inputs, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_pc;
    end else if (inc) begin
      pc <= pc + N'(PC_STEP);
    end
  end

endmodule : pc_reg

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives the asynchronous-read instruction memory
// from the PC, captures the returned word into the IF/ID register, and hands
// it to decode over valid/ready. Redirects override everything; ECALL halts.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int           N        = 32,
  parameter logic [N-1:0] RESET_PC = '0,
  parameter logic [N-1:0] NOP      = N'(NOP_WORD),
  parameter logic [N-1:0] ECALL    = N'(ECALL_WORD)
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

  state_t       state;
  logic [N-1:0] pc;
  logic [N-1:0] redirect_target;
  logic         advance;
  logic         is_ecall;
  logic         accept;

  logic         out_valid_q;
  logic [N-1:0] out_pc_q;
  logic [N-1:0] out_instr_q;
  logic         halted_q;
  logic [N-1:0] fetch_count_q;

  // Redirect targets are word aligned; the low two address bits are dropped.
  assign redirect_target = bus.redirect_pc & ~N'(3);

  // A fetch happens when running and the IF/ID slot is empty or being drained.
  assign advance  = (state == S_RUN) && (!out_valid_q || bus.out_ready);
  assign is_ecall = (bus.imem_data == ECALL);
  // A transfer to decode counts only if it is not squashed by a redirect.
  assign accept   = out_valid_q && bus.out_ready && !bus.redirect_valid;

  pc_reg #(
    .N        (N),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (bus.redirect_valid),
    .load_pc (redirect_target),
    .inc     (advance && !is_ecall),
    .pc      (pc)
  );

  // Memory is addressed straight from the PC, so a stall keeps it stable.
  assign bus.imem_addr   = pc;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_pc      = out_pc_q;
  assign bus.out_instr   = out_instr_q;
  assign bus.halted      = halted_q;
  assign bus.fetch_count = fetch_count_q;

  // Accepted-transfer counter; wraps naturally at 2^N.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count_q <= '0;
    end else if (accept) begin
      fetch_count_q <= fetch_count_q + N'(1);
    end
  end

  // Fetch sequencer and IF/ID register; a redirect squashes the slot and
  // (re)starts fetching from any state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_BOOT;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= NOP;
      halted_q    <= 1'b0;
    end else if (bus.redirect_valid) begin
      state       <= S_RUN;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      case (state)
        S_BOOT: begin
          state <= S_RUN;
        end
        S_RUN: begin
          if (advance) begin
            out_valid_q <= 1'b1;
            out_pc_q    <= pc;
            out_instr_q <= bus.imem_data;
            if (is_ecall) begin
              state    <= S_HALT;
              halted_q <= 1'b1;
            end
          end
        end
        S_HALT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state <= S_BOOT;
        end
      endcase
    end
  end

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of per-cycle stimulus with
// hand-computed expected outputs, plus reset sequences around it.
module tb_fetch_unit;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_unit_if #(.N(32)) bus ();

  fetch_unit #(
    .N        (32),
    .RESET_PC (32'h0000_0000),
    .NOP      (NOP),
    .ECALL    (ECALL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Asynchronous-read instruction memory decoding addr[10:2].
  logic [31:0] mem [512];
  assign bus.imem_data = mem[bus.imem_addr[10:2]];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_valid, input logic [31:0] e_pc,
                           input logic [31:0] e_instr, input logic e_halted,
                           input logic [31:0] e_count, input logic [31:0] e_addr);
    check({tag, " out_valid"},   32'(bus.out_valid), 32'(e_valid));
    check({tag, " out_pc"},      bus.out_pc,         e_pc);
    check({tag, " out_instr"},   bus.out_instr,      e_instr);
    check({tag, " halted"},      32'(bus.halted),    32'(e_halted));
    check({tag, " fetch_count"}, bus.fetch_count,    e_count);
    check({tag, " imem_addr"},   bus.imem_addr,      e_addr);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_halted;
    logic [31:0] e_count;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vecs [24];

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    for (int i = 0; i < 512; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[4] = ECALL;  // address 0x10

    //          rdy  rd  rpc            vld out_pc         out_instr      hlt cnt addr
    vecs[0]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        NOP,           1'b0, 0, 32'h0};        // BOOT edge
    vecs[1]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0,        32'hA000_0000, 1'b0, 0, 32'h4};        // first capture
    vecs[2]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h4,        32'hA000_0001, 1'b0, 1, 32'h8};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h8,        32'hA000_0002, 1'b0, 2, 32'hC};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h8,        32'hA000_0002, 1'b0, 2, 32'hC};        // stall x3
    vecs[5]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h8,        32'hA000_0002, 1'b0, 2, 32'hC};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h8,        32'hA000_0002, 1'b0, 2, 32'hC};
    vecs[7]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'hC,        32'hA000_0003, 1'b0, 3, 32'h10};       // resume at C
    vecs[8]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h10,       ECALL,         1'b1, 4, 32'h10};       // ECALL captured
    vecs[9]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h10,       ECALL,         1'b1, 4, 32'h10};       // held until accepted
    vecs[10] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h10,       ECALL,         1'b1, 5, 32'h10};       // accepted, slot clears
    vecs[11] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h10,       ECALL,         1'b1, 5, 32'h10};       // no further fetch
    vecs[12] = '{1'b1, 1'b1, 32'h40,       1'b0, 32'h10,       ECALL,         1'b0, 5, 32'h40};       // redirect out of halt
    vecs[13] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h40,       32'hA000_0010, 1'b0, 5, 32'h44};
    vecs[14] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h40,       32'hA000_0010, 1'b0, 5, 32'h44};       // stall
    vecs[15] = '{1'b0, 1'b1, 32'h103,      1'b0, 32'h40,       32'hA000_0010, 1'b0, 5, 32'h100};      // redirect while stalled
    vecs[16] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h100,      32'hA000_0040, 1'b0, 5, 32'h104};      // target valid at t+2
    vecs[17] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h100,     32'hA000_0040, 1'b0, 5, 32'hFFFF_FFFC}; // squash while ready
    vecs[18] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC, 32'hA000_01FF, 1'b0, 5, 32'h0};       // PC wraps
    vecs[19] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h0,        32'hA000_0000, 1'b0, 6, 32'h4};
    vecs[20] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h4,        32'hA000_0001, 1'b0, 7, 32'h8};
    vecs[21] = '{1'b1, 1'b1, 32'h20,       1'b0, 32'h4,        32'hA000_0001, 1'b0, 7, 32'h20};
    vecs[22] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h20,       32'hA000_0008, 1'b0, 7, 32'h24};
    vecs[23] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h20,       32'hA000_0008, 1'b0, 7, 32'h24};       // stalled at 0x20

    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    // Reset values while rst is held across an edge.
    step();
    check_all("reset", 1'b0, 32'h0, NOP, 1'b0, 32'h0, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      bus.out_ready      = vecs[i].ready;
      bus.redirect_valid = vecs[i].redir;
      bus.redirect_pc    = vecs[i].rpc;
      step();
      check_all($sformatf("v%0d", i), vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_instr,
                vecs[i].e_halted, vecs[i].e_count, vecs[i].e_addr);
    end

    // Asynchronous reset mid-stream while stalled with a redirect pending.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h80;
    #1 rst = 1'b1;
    #1;
    check_all("async_rst", 1'b0, 32'h0, NOP, 1'b0, 32'h0, 32'h0);
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b1;
    step();
    rst = 1'b0;
    step();
    check_all("restart_boot", 1'b0, 32'h0, NOP, 1'b0, 32'h0, 32'h0);
    step();
    check_all("restart_first", 1'b1, 32'h0, 32'hA000_0000, 1'b0, 32'h0, 32'h4);
    step();
    check_all("restart_second", 1'b1, 32'h4, 32'hA000_0001, 1'b0, 32'h1, 32'h8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fetch_unit
